multicycle_ctrl: RTL and testbench

Multi-cycle control FSM for the RV32I core. It takes the opcode and the instruction-format class from the main decoder and sequences the shared datapath through fetch, decode, execute, memory and writeback, one instruction at a time. It drives every datapath enable and mux select, runs the req/ready handshake to the unified memory port, and flags illegal opcodes.

---
 rtl/multicycle_ctrl_pkg.sv | 80 ++++++++
 rtl/multicycle_ctrl_if.sv | 32 +++
 rtl/multicycle_ctrl_outdec.sv | 118 +++++++++++
 rtl/multicycle_ctrl.sv | 79 +++++++
 tb/tb_multicycle_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and constants for the RV32I multi-cycle control FSM.
package rv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC   = 4'd2,
        S_ALUWB  = 4'd3,
        S_MEMADR = 4'd4,
        S_MEMRD  = 4'd5,
        S_MEMWB  = 4'd6,
        S_MEMWR  = 4'd7,
        S_BRANCH = 4'd8,
        S_BRTAKE = 4'd9,
        S_JAL    = 4'd10,
        S_JALR   = 4'd11,
        S_UPPER  = 4'd12,
        S_TRAP   = 4'd13
    } state_e;

    typedef enum logic [1:0] {
        ALU_A_RS1   = 2'd0,
        ALU_A_OLDPC = 2'd1,
        ALU_A_PC    = 2'd2,
        ALU_A_ZERO  = 2'd3
    } alu_a_e;

    typedef enum logic [1:0] {
        ALU_B_RS2  = 2'd0,
        ALU_B_IMM  = 2'd1,
        ALU_B_FOUR = 2'd2
    } alu_b_e;

    typedef enum logic [1:0] {
        ALU_OP_ADD   = 2'd0,
        ALU_OP_FUNCT = 2'd1,
        ALU_OP_CMP   = 2'd2
    } alu_op_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'd0,
        RES_MEM = 2'd1,
        RES_PC  = 2'd2
    } result_sel_e;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ITYPE_R = 4'b1000;
    localparam logic [3:0] ITYPE_I = 4'b1001;
    localparam logic [3:0] ITYPE_U = 4'b1010;
    localparam logic [3:0] ITYPE_J = 4'b1011;
    localparam logic [3:0] ITYPE_S = 4'b0100;
    localparam logic [3:0] ITYPE_B = 4'b0101;

    // True when the opcode is one the sequencer knows how to execute.
    function automatic logic op_known(logic [6:0] op);
        case (op)
            OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

    // True when the decoder reported one of the defined format classes.
    function automatic logic type_known(logic [3:0] t);
        case (t)
            ITYPE_R, ITYPE_I, ITYPE_U, ITYPE_J, ITYPE_S, ITYPE_B: return 1'b1;
            default:                                              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Decoder inputs, memory handshake and datapath controls of the sequencer.
interface multicycle_ctrl_if;
    logic [6:0] op;
    logic [3:0] instr_type;
    logic       branch_taken;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       ir_we;
    logic       pc_we;
    logic       pc_src;
    logic       reg_we;
    logic [1:0] alu_a_sel;
    logic [1:0] alu_b_sel;
    logic [1:0] alu_op;
    logic [1:0] result_sel;
    logic       instr_retired;
    logic       illegal;

    modport master (
        input  op, instr_type, branch_taken, mem_ready,
        output mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, reg_we,
               alu_a_sel, alu_b_sel, alu_op, result_sel, instr_retired, illegal
    );

    modport slave (
        output op, instr_type, branch_taken, mem_ready,
        input  mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, reg_we,
               alu_a_sel, alu_b_sel, alu_op, result_sel, instr_retired, illegal
    );
endinterface

// File: rtl/multicycle_ctrl_outdec.sv
// State-to-controls decode. Pure combinational; reset forces every control low
// asynchronously so an in-flight memory request drops the moment rst_n falls.
module ctrl_outdec
    import rv_ctrl_pkg::*;
(
    input  state_e     state,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [3:0] instr_type,
    input  logic       mem_ready,
    input  logic       branch_taken,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       ir_we,
    output logic       pc_we,
    output logic       pc_src,
    output logic       reg_we,
    output logic [1:0] alu_a_sel,
    output logic [1:0] alu_b_sel,
    output logic [1:0] alu_op,
    output logic [1:0] result_sel,
    output logic       instr_retired,
    output logic       illegal
);

    // Moore decode per state, with mem_ready/branch_taken qualifying exit strobes.
    always_comb begin
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr_sel  = 1'b0;
        ir_we         = 1'b0;
        pc_we         = 1'b0;
        pc_src        = 1'b0;
        reg_we        = 1'b0;
        alu_a_sel     = ALU_A_RS1;
        alu_b_sel     = ALU_B_RS2;
        alu_op        = ALU_OP_ADD;
        result_sel    = RES_ALU;
        instr_retired = 1'b0;
        illegal       = 1'b0;
        if (rst_n) begin
            case (state)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    alu_a_sel = ALU_A_PC;
                    alu_b_sel = ALU_B_FOUR;
                    ir_we     = mem_ready;
                    pc_we     = mem_ready;
                end
                S_DECODE: begin
                    illegal = !(op_known(op) && type_known(instr_type));
                end
                S_EXEC: begin
                    alu_b_sel = (instr_type == ITYPE_R) ? ALU_B_RS2 : ALU_B_IMM;
                    alu_op    = ALU_OP_FUNCT;
                end
                S_UPPER: begin
                    alu_a_sel = (op == OP_LUI) ? ALU_A_ZERO : ALU_A_OLDPC;
                    alu_b_sel = ALU_B_IMM;
                end
                S_ALUWB: begin
                    reg_we        = 1'b1;
                    instr_retired = 1'b1;
                end
                S_MEMADR: begin
                    alu_b_sel = ALU_B_IMM;
                end
                S_MEMRD: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                end
                S_MEMWB: begin
                    reg_we        = 1'b1;
                    result_sel    = RES_MEM;
                    instr_retired = 1'b1;
                end
                S_MEMWR: begin
                    mem_req       = 1'b1;
                    mem_we        = 1'b1;
                    mem_addr_sel  = 1'b1;
                    instr_retired = mem_ready;
                end
                S_BRANCH: begin
                    alu_op        = ALU_OP_CMP;
                    instr_retired = !branch_taken;
                end
                S_BRTAKE: begin
                    alu_a_sel     = ALU_A_OLDPC;
                    alu_b_sel     = ALU_B_IMM;
                    pc_we         = 1'b1;
                    instr_retired = 1'b1;
                end
                S_JAL: begin
                    alu_a_sel     = ALU_A_OLDPC;
                    alu_b_sel     = ALU_B_IMM;
                    pc_we         = 1'b1;
                    reg_we        = 1'b1;
                    result_sel    = RES_PC;
                    instr_retired = 1'b1;
                end
                S_JALR: begin
                    alu_b_sel     = ALU_B_IMM;
                    pc_we         = 1'b1;
                    pc_src        = 1'b1;
                    reg_we        = 1'b1;
                    result_sel    = RES_PC;
                    instr_retired = 1'b1;
                end
                S_TRAP: begin
                    illegal = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: owns the state register and next-state logic,
// delegating control decode to ctrl_outdec.
module multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter bit RESET_STATE_TRAP = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    multicycle_ctrl_if.master bus
);

    state_e state, state_nxt;

    // Next state; op and instr_type stay valid from DECODE until the next FETCH.
    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:  if (bus.mem_ready) state_nxt = S_DECODE;
            S_DECODE: begin
                if (!(op_known(bus.op) && type_known(bus.instr_type))) begin
                    state_nxt = RESET_STATE_TRAP ? S_TRAP : S_FETCH;
                end else begin
                    case (bus.op)
                        OP_RTYPE, OP_ITYPE: state_nxt = S_EXEC;
                        OP_LOAD, OP_STORE:  state_nxt = S_MEMADR;
                        OP_BRANCH:          state_nxt = S_BRANCH;
                        OP_JAL:             state_nxt = S_JAL;
                        OP_JALR:            state_nxt = S_JALR;
                        OP_LUI, OP_AUIPC:   state_nxt = S_UPPER;
                        default:            state_nxt = S_FETCH;
                    endcase
                end
            end
            S_EXEC:   state_nxt = S_ALUWB;
            S_UPPER:  state_nxt = S_ALUWB;
            S_ALUWB:  state_nxt = S_FETCH;
            S_MEMADR: state_nxt = (bus.op == OP_LOAD) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (bus.mem_ready) state_nxt = S_MEMWB;
            S_MEMWB:  state_nxt = S_FETCH;
            S_MEMWR:  if (bus.mem_ready) state_nxt = S_FETCH;
            S_BRANCH: state_nxt = bus.branch_taken ? S_BRTAKE : S_FETCH;
            S_BRTAKE: state_nxt = S_FETCH;
            S_JAL:    state_nxt = S_FETCH;
            S_JALR:   state_nxt = S_FETCH;
            S_TRAP:   state_nxt = S_TRAP;
            default:  state_nxt = S_FETCH;
        endcase
    end

    // State register; reset parks the sequencer at FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= state_nxt;
    end

    ctrl_outdec u_outdec (
        .state         (state),
        .rst_n         (rst_n),
        .op            (bus.op),
        .instr_type    (bus.instr_type),
        .mem_ready     (bus.mem_ready),
        .branch_taken  (bus.branch_taken),
        .mem_req       (bus.mem_req),
        .mem_we        (bus.mem_we),
        .mem_addr_sel  (bus.mem_addr_sel),
        .ir_we         (bus.ir_we),
        .pc_we         (bus.pc_we),
        .pc_src        (bus.pc_src),
        .reg_we        (bus.reg_we),
        .alu_a_sel     (bus.alu_a_sel),
        .alu_b_sel     (bus.alu_b_sel),
        .alu_op        (bus.alu_op),
        .result_sel    (bus.result_sel),
        .instr_retired (bus.instr_retired),
        .illegal       (bus.illegal)
    );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction expected control traces built from
// the instruction class, checked cycle by cycle on two DUTs (NOP / trap modes).
module tb_multicycle_ctrl;

    localparam logic [1:0] SA_RS1 = 2'd0, SA_OLDPC = 2'd1, SA_PC = 2'd2, SA_ZERO = 2'd3;
    localparam logic [1:0] SB_RS2 = 2'd0, SB_IMM = 2'd1, SB_FOUR = 2'd2;
    localparam logic [1:0] SO_FUNCT = 2'd1, SO_CMP = 2'd2;
    localparam logic [1:0] SR_MEM = 2'd1, SR_PC = 2'd2;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       mem_addr_sel;
        logic       ir_we;
        logic       pc_we;
        logic       pc_src;
        logic       reg_we;
        logic [1:0] alu_a;
        logic [1:0] alu_b;
        logic [1:0] alu_op;
        logic [1:0] result_sel;
        logic       retired;
        logic       illegal;
    } ctl_t;

    typedef struct {
        logic rdy;
        logic tkn;
        ctl_t exp;
    } cyc_t;

    logic clk = 1'b0;
    logic rst0_n = 1'b0;
    logic rst1_n = 1'b0;
    logic [6:0] op = '0;
    logic [3:0] itype = '0;
    logic rdy = 1'b0;
    logic tkn = 1'b0;

    cyc_t q[$];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    multicycle_ctrl_if u_if0 ();
    multicycle_ctrl_if u_if1 ();

    assign u_if0.op = op;
    assign u_if0.instr_type = itype;
    assign u_if0.mem_ready = rdy;
    assign u_if0.branch_taken = tkn;
    assign u_if1.op = op;
    assign u_if1.instr_type = itype;
    assign u_if1.mem_ready = rdy;
    assign u_if1.branch_taken = tkn;

    multicycle_ctrl #(.RESET_STATE_TRAP(1'b0)) u_dut0 (
        .clk   (clk),
        .rst_n (rst0_n),
        .bus   (u_if0.master)
    );

    multicycle_ctrl #(.RESET_STATE_TRAP(1'b1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst1_n),
        .bus   (u_if1.master)
    );

    task automatic chk(input string tag, input logic [16:0] got, input logic [16:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic ctl_t sample(input int sel);
        ctl_t s;
        if (sel == 0) begin
            s = {u_if0.mem_req, u_if0.mem_we, u_if0.mem_addr_sel, u_if0.ir_we, u_if0.pc_we,
                 u_if0.pc_src, u_if0.reg_we, u_if0.alu_a_sel, u_if0.alu_b_sel, u_if0.alu_op,
                 u_if0.result_sel, u_if0.instr_retired, u_if0.illegal};
        end else begin
            s = {u_if1.mem_req, u_if1.mem_we, u_if1.mem_addr_sel, u_if1.ir_we, u_if1.pc_we,
                 u_if1.pc_src, u_if1.reg_we, u_if1.alu_a_sel, u_if1.alu_b_sel, u_if1.alu_op,
                 u_if1.result_sel, u_if1.instr_retired, u_if1.illegal};
        end
        return s;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic op_ok(input logic [6:0] o);
        case (o)
            7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic type_ok(input logic [3:0] t);
        case (t)
            4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b0100, 4'b0101: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] class_of(input logic [6:0] o);
        case (o)
            7'b0110011:                         return 4'b1000;
            7'b0010011, 7'b0000011, 7'b1100111: return 4'b1001;
            7'b0110111, 7'b0010111:             return 4'b1010;
            7'b1101111:                         return 4'b1011;
            7'b0100011:                         return 4'b0100;
            default:                            return 4'b0101;
        endcase
    endfunction

    task automatic push(input logic r, input logic k, input ctl_t c);
        cyc_t e;
        e.rdy = r;
        e.tkn = k;
        e.exp = c;
        q.push_back(e);
    endtask

    // Expected per-cycle controls for one instruction; fw/mw are wait cycles
    // before mem_ready on fetch and on the data access.
    task automatic build(input logic [6:0] o, input logic [3:0] t, input int fw,
                         input int mw, input logic tk);
        ctl_t c;
        logic ok;
        for (int i = 0; i <= fw; i++) begin
            c = '0;
            c.mem_req = 1'b1;
            c.alu_a = SA_PC;
            c.alu_b = SB_FOUR;
            c.ir_we = (i == fw);
            c.pc_we = (i == fw);
            push(i == fw, rb(), c);
        end
        ok = op_ok(o) && type_ok(t);
        c = '0;
        c.illegal = !ok;
        push(rb(), rb(), c);
        if (!ok) return;
        case (o)
            7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: begin
                c = '0;
                if (o == 7'b0110111) begin
                    c.alu_a = SA_ZERO;
                    c.alu_b = SB_IMM;
                end else if (o == 7'b0010111) begin
                    c.alu_a = SA_OLDPC;
                    c.alu_b = SB_IMM;
                end else begin
                    c.alu_a = SA_RS1;
                    c.alu_b = (t == 4'b1000) ? SB_RS2 : SB_IMM;
                    c.alu_op = SO_FUNCT;
                end
                push(rb(), rb(), c);
                c = '0;
                c.reg_we = 1'b1;
                c.retired = 1'b1;
                push(rb(), rb(), c);
            end
            7'b0000011, 7'b0100011: begin
                c = '0;
                c.alu_b = SB_IMM;
                push(rb(), rb(), c);
                for (int i = 0; i <= mw; i++) begin
                    c = '0;
                    c.mem_req = 1'b1;
                    c.mem_addr_sel = 1'b1;
                    c.mem_we = (o == 7'b0100011);
                    c.retired = (o == 7'b0100011) && (i == mw);
                    push(i == mw, rb(), c);
                end
                if (o == 7'b0000011) begin
                    c = '0;
                    c.reg_we = 1'b1;
                    c.result_sel = SR_MEM;
                    c.retired = 1'b1;
                    push(rb(), rb(), c);
                end
            end
            7'b1100011: begin
                c = '0;
                c.alu_op = SO_CMP;
                c.retired = !tk;
                push(rb(), tk, c);
                if (tk) begin
                    c = '0;
                    c.alu_a = SA_OLDPC;
                    c.alu_b = SB_IMM;
                    c.pc_we = 1'b1;
                    c.retired = 1'b1;
                    push(rb(), rb(), c);
                end
            end
            7'b1101111, 7'b1100111: begin
                c = '0;
                c.alu_a = (o == 7'b1101111) ? SA_OLDPC : SA_RS1;
                c.alu_b = SB_IMM;
                c.pc_we = 1'b1;
                c.pc_src = (o == 7'b1100111);
                c.reg_we = 1'b1;
                c.result_sel = SR_PC;
                c.retired = 1'b1;
                push(rb(), rb(), c);
            end
            default: ;
        endcase
    endtask

    // Entered and left at posedge+1; drives each cycle's inputs, checks at negedge.
    task automatic run_q(input int sel, input string tag, input int limit);
        for (int i = 0; i < q.size() && i < limit; i++) begin
            rdy = q[i].rdy;
            tkn = q[i].tkn;
            @(negedge clk);
            chk($sformatf("%s[%0d]", tag, i), sample(sel), q[i].exp);
            @(posedge clk);
            #1;
        end
        q.delete();
    endtask

    task automatic do_instr(input int sel, input string tag, input logic [6:0] o,
                            input logic [3:0] t, input int fw, input int mw, input logic tk);
        op = o;
        itype = t;
        build(o, t, fw, mw, tk);
        run_q(sel, tag, 1000);
    endtask

    initial begin
        ctl_t c;
        logic [6:0] ro;
        logic [3:0] rt;
        logic [6:0] ops [9];
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

        repeat (2) @(posedge clk);
        #1;
        rdy = 1'b1;
        @(negedge clk);
        chk("reset0", sample(0), '0);
        chk("reset1", sample(1), '0);
        @(posedge clk);
        #1;
        rst0_n = 1'b1;

        // directed cases
        do_instr(0, "add",   7'b0110011, 4'b1000, 0, 0, 1'b0);
        do_instr(0, "lw_w3", 7'b0000011, 4'b1001, 0, 3, 1'b0);
        do_instr(0, "beq_t", 7'b1100011, 4'b0101, 0, 0, 1'b1);
        do_instr(0, "beq_n", 7'b1100011, 4'b0101, 0, 0, 1'b0);
        do_instr(0, "jalr",  7'b1100111, 4'b1001, 0, 0, 1'b0);
        do_instr(0, "jal",   7'b1101111, 4'b1011, 2, 0, 1'b0);
        do_instr(0, "sw_w2", 7'b0100011, 4'b0100, 0, 2, 1'b0);
        do_instr(0, "lui",   7'b0110111, 4'b1010, 0, 0, 1'b0);
        do_instr(0, "auipc", 7'b0010111, 4'b1010, 1, 0, 1'b0);
        do_instr(0, "addi",  7'b0010011, 4'b1001, 0, 0, 1'b0);
        do_instr(0, "ill",   7'b1111111, 4'b1000, 0, 0, 1'b0);
        do_instr(0, "badty", 7'b0110011, 4'b1111, 0, 0, 1'b0);

        // randomized instruction stream
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                do ro = 7'($urandom); while (op_ok(ro));
            end else begin
                ro = ops[$urandom_range(0, 8)];
            end
            rt = class_of(ro);
            if ($urandom_range(0, 7) == 0) begin
                do rt = 4'($urandom); while (type_ok(rt));
            end
            do_instr(0, $sformatf("rnd%0d", n), ro, rt,
                     ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0,
                     ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0,
                     rb());
        end

        // reset in the middle of a stalled store
        op = 7'b0100011;
        itype = 4'b0100;
        build(7'b0100011, 4'b0100, 0, 5, 1'b0);
        run_q(0, "swrst", 4);
        rdy = 1'b0;
        #2;
        chk("swrst_pre", 17'({u_if0.mem_req, u_if0.mem_we}), 17'b11);
        rst0_n = 1'b0;
        #1;
        chk("swrst_drop", sample(0), '0);
        @(posedge clk);
        #1;
        rst0_n = 1'b1;
        do_instr(0, "post_rst", 7'b0110011, 4'b1000, 1, 0, 1'b0);

        // trap mode on the second instance
        rst0_n = 1'b0;
        rst1_n = 1'b1;
        op = 7'b1111111;
        itype = 4'b1000;
        build(7'b1111111, 4'b1000, 0, 0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            c = '0;
            c.illegal = 1'b1;
            push(rb(), rb(), c);
        end
        run_q(1, "trap", 1000);
        #2;
        rst1_n = 1'b0;
        #1;
        chk("trap_rst", sample(1), '0);
        @(posedge clk);
        #1;
        rst1_n = 1'b1;
        do_instr(1, "trap_add", 7'b0110011, 4'b1000, 1, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
